// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 32-bit down-counting timer on the CPU bus.
// Prescaled tick, optional auto-reload, one-cycle expiry interrupt.
module bus_timer #(
    parameter int unsigned PRESCALE = 50
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [1:0]  address,
    input  logic [31:0] data,
    input  logic        we,
    input  logic        start,
    output logic        busy,
    output logic [31:0] q,
    output logic        int_out
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_READ
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic          latch, apply, capture;

    logic [2:0]    ctrl_q, ctrl_d, ctrl_eff;
    logic [31:0]   reload_q, reload_d;
    logic [31:0]   count_q, count_d;
    logic          exp_q, exp_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          int_q, int_d;
    logic [31:0]   q_q, rdata;

    logic          wr_ctrl, wr_reload, wr_count, wr_status;
    logic          tick, expire;

    // Bus FSM state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Bus FSM next state; start only matters in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_ACCESS;
            S_ACCESS: state_d = S_READ;
            S_READ:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Bus FSM outputs: busy, request latch, write apply, read capture.
    always_comb begin
        busy    = (state_q != S_IDLE);
        latch   = (state_q == S_IDLE) && start;
        apply   = (state_q == S_ACCESS) && we_q;
        capture = (state_q == S_READ);
    end

    // Latch the request so the initiator may drop its signals.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (latch) begin
            addr_q  <= address;
            wdata_q <= data;
            we_q    <= we;
        end
    end

    // Register writes, prescaler, counter and expiry arbitration.
    always_comb begin
        wr_ctrl   = apply && (addr_q == 2'd0);
        wr_reload = apply && (addr_q == 2'd1);
        wr_count  = apply && (addr_q == 2'd2);
        wr_status = apply && (addr_q == 2'd3);

        tick     = ctrl_q[0] && (presc_q == PMAX);
        expire   = tick && (count_q <= 32'd1) && !wr_count;
        ctrl_eff = wr_ctrl ? wdata_q[2:0] : ctrl_q;

        presc_d = presc_q + PW'(1);
        if (wr_count || !ctrl_q[0] || tick) presc_d = '0;

        count_d = count_q;
        if (wr_count)    count_d = wdata_q;
        else if (expire) count_d = ctrl_eff[1] ? reload_q : 32'd0;
        else if (tick)   count_d = count_q - 32'd1;

        ctrl_d = ctrl_q;
        if (wr_ctrl)                   ctrl_d = wdata_q[2:0];
        else if (expire && !ctrl_q[1]) ctrl_d[0] = 1'b0;

        reload_d = wr_reload ? wdata_q : reload_q;

        exp_d = exp_q;
        if (expire)                      exp_d = 1'b1;
        else if (wr_status && wdata_q[0]) exp_d = 1'b0;

        int_d = expire && ctrl_q[2];

        rdata = '0;
        unique case (addr_q)
            2'd0:    rdata = {29'd0, ctrl_q};
            2'd1:    rdata = reload_q;
            2'd2:    rdata = count_q;
            2'd3:    rdata = {31'd0, exp_q};
            default: rdata = '0;
        endcase
    end

    // Timer state update.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ctrl_q   <= '0;
            reload_q <= '0;
            count_q  <= '0;
            exp_q    <= 1'b0;
            presc_q  <= '0;
            int_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            exp_q    <= exp_d;
            presc_q  <= presc_d;
            int_q    <= int_d;
        end
    end

    // Read data capture; held until the next access completes.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)      q_q <= '0;
        else if (capture) q_q <= rdata;
    end

    assign q       = q_q;
    assign int_out = int_q;

endmodule
